// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles big-endian 32-bit words into instruction memory,
// then releases the core. Optional trailing XOR checksum via `define LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_run,
   output logic              busy,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_WRITE,
`ifdef LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [16:0] MAX_L = 17'(MAX_WORDS);

   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [23:0]       asm_q, asm_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [ADDR_W:0]   wc_q, wc_d;
   logic [31:0]       wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   logic        accept;
   logic        restart;
   logic [15:0] len_full;
   logic [16:0] wc_next;
   state_t      end_state;

`ifdef LOADER_CHECKSUM_EN
   assign in_ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHK);
   assign end_state = S_CHK;
`else
   assign in_ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA);
   assign end_state = S_DONE;
`endif

   assign imem_we    = (state_q == S_WRITE);
   assign busy       = in_ready || imem_we;
   assign core_run   = (state_q == S_DONE);
   assign err        = (state_q == S_ERROR);
   assign imem_addr  = wc_q[ADDR_W-1:0];
   assign imem_wdata = wdata_q;
   assign word_count = wc_q;

   assign accept   = in_valid && in_ready;
   assign restart  = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                               (state_q == S_ERROR));
   assign len_full = {len_q[15:8], in_data};
   assign wc_next  = 17'(wc_q) + 17'd1;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      asm_d   = asm_q;
      bcnt_d  = bcnt_q;
      wc_d    = wc_q;
      wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = csum_q;
      if (accept && (state_q != S_CHK)) csum_d = csum_q ^ in_data;
`endif
      case (state_q)
         S_LEN_HI: if (accept) begin
            len_d[15:8] = in_data;
            state_d     = S_LEN_LO;
         end
         S_LEN_LO: if (accept) begin
            len_d[7:0] = in_data;
            bcnt_d     = 2'd0;
            if (len_full == 16'd0)              state_d = end_state;
            else if ({1'b0, len_full} > MAX_L)  state_d = S_ERROR;
            else                                state_d = S_DATA;
         end
         S_DATA: if (accept) begin
            bcnt_d = bcnt_q + 2'd1;
            asm_d  = {asm_q[15:0], in_data};
            // The word register only changes on the 4th byte, so memory data stays stable otherwise.
            if (bcnt_q == 2'd3) begin
               wdata_d = {asm_q, in_data};
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            wc_d    = wc_q + 1'b1;
            state_d = (wc_next < {1'b0, len_q}) ? S_DATA : end_state;
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHK: if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
`endif
         S_IDLE, S_DONE, S_ERROR: ;
         default: state_d = S_IDLE;
      endcase
      if (restart) begin
         state_d = S_LEN_HI;
         len_d   = 16'd0;
         bcnt_d  = 2'd0;
         wc_d    = '0;
`ifdef LOADER_CHECKSUM_EN
         csum_d  = 8'd0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         len_q   <= 16'd0;
         asm_q   <= 24'd0;
         bcnt_q  <= 2'd0;
         wc_q    <= '0;
         wdata_q <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         asm_q   <= asm_d;
         bcnt_q  <= bcnt_d;
         wc_q    <= wc_d;
         wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a stream-level model predicts the memory writes and
// final outcome; a negedge monitor checks every write and the hold behaviour of imem_wdata.
module tb_prog_loader;
   localparam int AW   = 8;
   localparam int MAXW = 256;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
   logic [7:0]    in_data = 8'd0;
   logic          in_ready, imem_we, core_run, busy, err;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   word_count;

   prog_loader #(.ADDR_W(AW), .MAX_WORDS(MAXW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .core_run(core_run), .busy(busy), .err(err),
      .word_count(word_count));

   always #5 clk = ~clk;

   int             vectors = 0, miscompares = 0;
   logic [AW+31:0] exp_q[$];
   logic [7:0]     stream[$];
   logic [31:0]    last_wd = 32'd0;
   bit             gap_mode = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every write must match the head of the expected-write queue.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                        imem_addr, imem_wdata);
            end else begin
               logic [AW+31:0] e;
               e = exp_q.pop_front();
               chk("write", 64'({imem_addr, imem_wdata}), 64'(e));
               last_wd = e[31:0];
            end
            chk("ready_in_write", 64'(in_ready), 64'd0);
            chk("busy_in_write", 64'(busy), 64'd1);
         end else begin
            chk("wdata_hold", 64'(imem_wdata), 64'(last_wd));
         end
         chk("run_and_busy", 64'(core_run & (busy | err)), 64'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit pulse_start);
      int gaps;
      int n;
      gaps = gap_mode ? 1 : int'($urandom_range(0, 3));
      in_valid = 1'b0;
      if (pulse_start) start_pulse();
      repeat (gaps) step();
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (in_ready !== 1'b1 && n < 100);
      if (in_ready !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL send_byte_timeout: got in_ready %b expected 1 within 100 cycles", in_ready);
      end
      step();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_imem_we"}, 64'(imem_we), 64'd0);
      chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
      chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
      chk({tag, "_core_run"}, 64'(core_run), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_word_count"}, 64'(word_count), 64'd0);
   endtask

   // Sends the prepared stream after a start and checks the final outcome.
   task automatic run_stream(input bit exp_err, input int exp_wc, input bit busy_starts);
      int n;
      start_pulse();
      foreach (stream[i])
         send_byte(stream[i], busy_starts && (i > 0) && ($urandom_range(0, 3) == 0));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (core_run !== 1'b1 && err !== 1'b1 && n < 500);
      chk("final_err", 64'(err), 64'(exp_err));
      chk("final_core_run", 64'(core_run), 64'(!exp_err));
      chk("final_word_count", 64'(word_count), 64'(exp_wc));
      chk("final_busy", 64'(busy), 64'd0);
      chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
      step();
   endtask

   // Model: a program of L random words lands at addresses 0..L-1 in order.
   task automatic build(input int L, input bit bad_csum, output bit exp_err, output int exp_wc);
      logic [31:0] w;
      logic [7:0]  x;
      stream.delete();
      stream.push_back(8'(L >> 8));
      stream.push_back(8'(L));
      exp_err = (L > MAXW);
      exp_wc  = exp_err ? 0 : L;
      if (!exp_err) begin
         for (int k = 0; k < L; k++) begin
            w = $urandom;
            for (int j = 3; j >= 0; j--) stream.push_back(8'(w >> (8 * j)));
            exp_q.push_back({AW'(k), w});
         end
`ifdef LOADER_CHECKSUM_EN
         x = 8'd0;
         foreach (stream[i]) x ^= stream[i];
         stream.push_back(bad_csum ? ~x : x);
         exp_err = bad_csum;
`else
         x = 8'd0;
         if (bad_csum) x = 8'd1;
`endif
      end
   endtask

   task automatic run_load(input int L, input bit bad_csum, input bit busy_starts);
      bit e;
      int wc;
      build(L, bad_csum, e, wc);
      run_stream(e, wc, busy_starts);
   endtask

   initial begin
      bit e;
      int wc;
      int L;
      #2;
      check_reset_outputs("por");
      step();
      rst_n = 1'b1;
      step();

      // Single hand-checked word.
      stream = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05};
`ifdef LOADER_CHECKSUM_EN
      stream.push_back(8'h2C);
`endif
      exp_q.push_back({8'h00, 32'h2008_0005});
      run_stream(1'b0, 1, 1'b0);
      chk("lit_wc_one", 64'(word_count), 64'd1);

      // Three words with in_valid toggling every other cycle.
      gap_mode = 1'b1;
      run_load(3, 1'b0, 1'b0);
      gap_mode = 1'b0;

      // Over-length program, then recovery, then exact maximum length.
      stream = '{8'h01, 8'h01};
      run_stream(1'b1, 0, 1'b0);
      run_load(2, 1'b0, 1'b0);
      run_load(MAXW, 1'b0, 1'b0);
      chk("lit_wc_max", 64'(word_count), 64'd256);

      // Empty program, with a start attempted while busy.
      run_load(0, 1'b0, 1'b1);
      chk("lit_wc_zero", 64'(word_count), 64'd0);

`ifdef LOADER_CHECKSUM_EN
      stream = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
      exp_q.push_back({8'h00, 32'hAABB_CCDD});
      run_stream(1'b0, 1, 1'b0);
      stream = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
      exp_q.push_back({8'h00, 32'hAABB_CCDD});
      run_stream(1'b1, 1, 1'b0);
`endif

      // Reset in the middle of word 1: word 0 stays written, word 1 never appears.
      build(3, 1'b0, e, wc);
      start_pulse();
      for (int i = 0; i < 8; i++) send_byte(stream[i], 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      chk("midrst_words_written", 64'(exp_q.size()), 64'd2);
      exp_q.delete();
      last_wd = 32'd0;
      repeat (3) step();
      rst_n = 1'b1;
      repeat (4) step();
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_run", 64'(core_run), 64'd0);
      run_load(2, 1'b0, 1'b0);

      // Randomized loads.
      for (int t = 0; t < 30; t++) begin
         case ($urandom_range(0, 9))
            0:       L = 0;
            1:       L = MAXW + 1 + int'($urandom_range(0, 65535 - MAXW - 1));
            default: L = int'($urandom_range(1, 6));
         endcase
         gap_mode = 1'($urandom_range(0, 1));
         run_load(L, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
